game_phase_ctrl: RTL and testbench

//   Game-phase sequencer for Keyboard Battleship. Tracks setup (P1/P2 ship placement),

---
 rtl/game_phase_ctrl_pkg.sv | 16 +
 rtl/game_phase_ctrl_if.sv | 18 +
 rtl/game_phase_ctrl_sat_counter.sv | 17 +
 rtl/game_phase_ctrl.sv | 67 ++++++
 tb/tb_game_phase_ctrl.sv | 131 +++++++++++++
 5 files changed

// File: rtl/game_phase_ctrl_pkg.sv
// game_phase_ctrl_pkg: shared state encoding, winner codes and default sizing for the phase sequencer
package game_phase_ctrl_pkg;
  typedef logic [2:0] state_t;
  localparam state_t IDLE     = 3'd0;
  localparam state_t P1_PLACE = 3'd1;
  localparam state_t P2_PLACE = 3'd2;
  localparam state_t P1_FIRE  = 3'd3;
  localparam state_t P2_FIRE  = 3'd4;
  localparam state_t OVER     = 3'd5;
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam int NUM_SHIPS_DEF = 5;
  localparam int WIN_HITS_DEF  = 17;
  localparam int CNT_W_DEF     = 5;
endpackage

// File: rtl/game_phase_ctrl_if.sv
// game_phase_ctrl_if: event pulses from keyboard/board logic in, phase flags and scores out
// slave (sequencer): start, place_valid, place_legal, fire_valid, fire_hit in;
//   p1place, p2place, p1fire, p2fire, game_over, winner, place_err, ships_placed, p1_hits, p2_hits out
// master (event source / display side): the mirror image
interface game_phase_ctrl_if import game_phase_ctrl_pkg::*; #(parameter int CNT_W = CNT_W_DEF);
  logic start, place_valid, place_legal, fire_valid, fire_hit;
  logic p1place, p2place, p1fire, p2fire, game_over, place_err;
  logic [1:0] winner;
  logic [CNT_W-1:0] ships_placed, p1_hits, p2_hits;
  modport master(
    output start, place_valid, place_legal, fire_valid, fire_hit,
    input p1place, p2place, p1fire, p2fire, game_over, place_err, winner, ships_placed, p1_hits, p2_hits
  );
  modport slave(
    input start, place_valid, place_legal, fire_valid, fire_hit,
    output p1place, p2place, p1fire, p2fire, game_over, place_err, winner, ships_placed, p1_hits, p2_hits
  );
endinterface

// File: rtl/game_phase_ctrl_sat_counter.sv
// sat_counter: up-counter that stops at MAX; clr wins over inc
// ports: clk, rst_n (async active-low), inc, clr in; q out
module sat_counter #(
  parameter int CNT_W = 5,
  parameter int MAX   = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (inc && q != CNT_W'(MAX)) q <= q + 1'b1;
endmodule

// File: rtl/game_phase_ctrl.sv
// game_phase_ctrl: Battleship phase sequencer (placement, alternating fire turns, game over)
// ports: clk, rst_n (async active-low), bus (game_phase_ctrl_if.slave: event pulses in, registered flags/scores out)
module game_phase_ctrl import game_phase_ctrl_pkg::*; #(
  parameter int NUM_SHIPS = NUM_SHIPS_DEF,
  parameter int WIN_HITS  = WIN_HITS_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input logic              clk,
  input logic              rst_n,
  game_phase_ctrl_if.slave bus
);
  state_t state, state_d;
  logic in_place, new_game, ship_inc, ship_done, p1_inc, p2_inc, p1_win, p2_win;
  logic err_d, over_d;
  logic [3:0] flags_d;
  logic [1:0] winner_d;
  assign in_place  = state == P1_PLACE || state == P2_PLACE;
  assign new_game  = bus.start && (state == IDLE || state == OVER);
  assign ship_inc  = in_place && bus.place_valid && bus.place_legal;
  // the commit that fills the fleet hands over to the next phase and restarts the count
  assign ship_done = ship_inc && bus.ships_placed == CNT_W'(NUM_SHIPS - 1);
  assign p1_inc    = state == P1_FIRE && bus.fire_valid && bus.fire_hit;
  assign p2_inc    = state == P2_FIRE && bus.fire_valid && bus.fire_hit;
  assign p1_win    = p1_inc && bus.p1_hits == CNT_W'(WIN_HITS - 1);
  assign p2_win    = p2_inc && bus.p2_hits == CNT_W'(WIN_HITS - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      {bus.p1place, bus.p2place, bus.p1fire, bus.p2fire} <= '0;
      bus.game_over <= 1'b0;
      bus.place_err <= 1'b0;
      bus.winner    <= WIN_NONE;
    end else begin
      state <= state_d;
      {bus.p1place, bus.p2place, bus.p1fire, bus.p2fire} <= flags_d;
      bus.game_over <= over_d;
      bus.place_err <= err_d;
      bus.winner    <= winner_d;
    end
  always_comb begin
    state_d = state;
    case (state)
      IDLE, OVER: state_d = bus.start ? P1_PLACE : state;
      P1_PLACE:   state_d = ship_done ? P2_PLACE : state;
      P2_PLACE:   state_d = ship_done ? P1_FIRE : state;
      P1_FIRE:    state_d = bus.fire_valid ? (p1_win ? OVER : P2_FIRE) : state;
      P2_FIRE:    state_d = bus.fire_valid ? (p2_win ? OVER : P1_FIRE) : state;
      default:    state_d = IDLE;
    endcase
  end
  // outputs are decoded from the next state so the registered flags line up with it
  always_comb begin
    flags_d  = {state_d == P1_PLACE, state_d == P2_PLACE, state_d == P1_FIRE, state_d == P2_FIRE};
    over_d   = state_d == OVER;
    err_d    = in_place && bus.place_valid && !bus.place_legal;
    winner_d = new_game ? WIN_NONE : p1_win ? WIN_P1 : p2_win ? WIN_P2 : bus.winner;
  end
  sat_counter #(.CNT_W(CNT_W), .MAX(NUM_SHIPS)) u_ships (
    .clk, .rst_n, .inc(ship_inc), .clr(new_game || ship_done), .q(bus.ships_placed)
  );
  sat_counter #(.CNT_W(CNT_W), .MAX(WIN_HITS)) u_p1_hits (
    .clk, .rst_n, .inc(p1_inc), .clr(new_game), .q(bus.p1_hits)
  );
  sat_counter #(.CNT_W(CNT_W), .MAX(WIN_HITS)) u_p2_hits (
    .clk, .rst_n, .inc(p2_inc), .clr(new_game), .q(bus.p2_hits)
  );
endmodule

// File: tb/tb_game_phase_ctrl.sv
// tb_game_phase_ctrl: directed scoreboard bench for game_phase_ctrl
module tb_game_phase_ctrl;
  typedef struct packed {
    logic p1place, p2place, p1fire, p2fire, game_over;
    logic [1:0] winner;
    logic place_err;
    logic [4:0] ships, p1h, p2h;
  } obs_t;
  typedef struct {
    int    due;
    string name;
    obs_t  exp;
  } ent_t;
  logic clk = 0, rst_n = 0;
  int cyc = 0, tests = 0, fails = 0;
  ent_t sb[$];
  ent_t ent;
  obs_t e, act;
  game_phase_ctrl_if #(.CNT_W(5)) bus();
  game_phase_ctrl #(.NUM_SHIPS(5), .WIN_HITS(17), .CNT_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign act = {bus.p1place, bus.p2place, bus.p1fire, bus.p2fire, bus.game_over, bus.winner,
                bus.place_err, bus.ships_placed, bus.p1_hits, bus.p2_hits};
  task automatic check(input string nm, input obs_t x);
    tests++;
    if (act !== x) begin
      fails++;
      $display("FAIL %s: got %h (flags=%b over=%b win=%b err=%b ships=%0d p1=%0d p2=%0d) expected %h",
               nm, act, act[22:19], act[18], act[17:16], act[15], act[14:10], act[9:5], act[4:0], x);
    end
  endtask
  always @(negedge clk)
    while (sb.size() > 0 && sb[0].due == cyc) begin
      ent = sb.pop_front();
      check(ent.name, ent.exp);
    end
  task automatic step(input logic s, pv, pl, fv, fh, input string nm);
    @(posedge clk);
    #1;
    {bus.start, bus.place_valid, bus.place_legal, bus.fire_valid, bus.fire_hit} = {s, pv, pl, fv, fh};
    sb.push_back('{cyc + 1, nm, e});
    e.place_err = 0;
  endtask
  task automatic place_fleet(input bit p2);
    for (int i = 1; i <= 4; i++) begin
      e.ships = 5'(i);
      step(0, 1, 1, 0, 0, p2 ? "p2_place" : "p1_place");
    end
    e.ships = 0;
    e.p1place = 0;
    e.p2place = !p2;
    e.p1fire = p2;
    step(0, 1, 1, 0, 0, p2 ? "p2_done" : "p1_done");
  endtask
  task automatic drain(input string nm);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL %s: %0d expectations still pending, required 0", nm, sb.size());
      sb.delete();
    end
  endtask
  initial begin
    {bus.start, bus.place_valid, bus.place_legal, bus.fire_valid, bus.fire_hit} = '0;
    e = '0;
    #12;
    check("reset", '0);
    #5 rst_n = 1;
    step(0, 0, 0, 0, 0, "idle_hold");
    step(0, 1, 1, 1, 1, "idle_ignore");
    e.p1place = 1;
    step(1, 1, 1, 0, 0, "start_idle");
    e.place_err = 1;
    step(0, 1, 0, 0, 0, "illegal");
    step(0, 0, 0, 1, 1, "err_pulse_fire_in_place");
    place_fleet(0);
    step(1, 0, 0, 0, 0, "start_in_place");
    e.place_err = 1;
    step(0, 1, 0, 1, 1, "p2_illegal");
    place_fleet(1);
    step(0, 1, 0, 0, 0, "place_in_fire");
    {e.p1fire, e.p2fire} = 2'b01;
    step(0, 0, 0, 1, 0, "p1_miss");
    {e.p1fire, e.p2fire} = 2'b10;
    e.p2h = 1;
    step(0, 1, 1, 1, 1, "p2_hit");
    step(1, 0, 0, 0, 0, "start_in_fire");
    for (int h = 1; h <= 16; h++) begin
      {e.p1fire, e.p2fire} = 2'b01;
      e.p1h = 5'(h);
      step(0, 0, 0, 1, 1, "p1_hit");
      {e.p1fire, e.p2fire} = 2'b10;
      step(0, 0, 0, 1, 0, "p2_miss");
    end
    {e.p1fire, e.p2fire} = 2'b00;
    e.p1h = 17;
    e.game_over = 1;
    e.winner = 2'b01;
    step(0, 0, 0, 1, 1, "p1_wins");
    step(0, 1, 0, 1, 1, "over_hold");
    e = '0;
    e.p1place = 1;
    step(1, 0, 0, 0, 0, "restart");
    place_fleet(0);
    place_fleet(1);
    {e.p1fire, e.p2fire} = 2'b01;
    e.p1h = 1;
    step(0, 0, 0, 1, 1, "p1_hit_b2b");
    {e.p1fire, e.p2fire} = 2'b10;
    e.p2h = 1;
    step(0, 0, 0, 1, 1, "p2_hit_b2b");
    {e.p1fire, e.p2fire} = 2'b01;
    e.p1h = 2;
    step(0, 0, 0, 1, 1, "p1_hit_again");
    step(0, 0, 0, 0, 0, "p2_turn_idle");
    drain("pre_reset_drain");
    @(negedge clk);
    #2 rst_n = 0;
    #1 check("async_reset", '0);
    @(negedge clk);
    rst_n = 1;
    e = '0;
    step(0, 0, 0, 1, 1, "post_reset_idle");
    step(0, 0, 0, 0, 0, "post_reset_hold");
    drain("final_drain");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
